// File: rtl/lop_norm_ctrl_if.sv
// Signal bundle between the normalisation controller, its requester, the LOP predictor
// and the result consumer.
interface lop_norm_ctrl_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_A;
  logic [DATA_WIDTH-1:0]  in_B;

  logic                   lop_enable;
  logic [DATA_WIDTH-1:0]  lop_data_A;
  logic [DATA_WIDTH-1:0]  lop_data_B;
  logic [SHIFT_WIDTH-1:0] lop_nshift;
  logic                   lop_nshift_correct;
  logic                   lop_not_zero;

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  res_mant;
  logic [SHIFT_WIDTH-1:0] res_shift;
  logic                   res_sign;
  logic                   res_zero;
  logic                   res_corr;
  logic                   res_hint;
  logic                   res_err;
  logic                   busy;

  modport master (
    output in_valid, in_A, in_B, lop_nshift, lop_nshift_correct, lop_not_zero, out_ready,
    input  in_ready, lop_enable, lop_data_A, lop_data_B, out_valid,
    input  res_mant, res_shift, res_sign, res_zero, res_corr, res_hint, res_err, busy
  );

  modport slave (
    input  in_valid, in_A, in_B, lop_nshift, lop_nshift_correct, lop_not_zero, out_ready,
    output in_ready, lop_enable, lop_data_A, lop_data_B, out_valid,
    output res_mant, res_shift, res_sign, res_zero, res_corr, res_hint, res_err, busy
  );
endinterface

// File: rtl/lop_norm_ctrl.sv
// Sequences a subtract-and-normalise operation around an external leading-one predictor,
// applying the one-bit LOP correction and flagging inconsistent predictions.
module lop_norm_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input logic           clk,
  input logic           rst,
  lop_norm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StPred, StNorm, StFix, StDone} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]  op_a_q, op_b_q;
  logic [DATA_WIDTH-1:0]  mag_q;
  logic [DATA_WIDTH-1:0]  norm_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   sign_q, zero_q, corr_q, hint_q, err_q;

  logic                    in_lt;
  logic [DATA_WIDTH:0]     diff_ab, diff_ba;
  logic [DATA_WIDTH-1:0]   mag_d;
  logic [2*DATA_WIDTH-1:0] shifted;
  logic                    shift_lost;
  logic                    mag_nz;
  logic                    need_fix;

  always_comb begin
    in_lt   = bus.in_A < bus.in_B;
    diff_ab = {1'b0, bus.in_A} - {1'b0, bus.in_B};
    diff_ba = {1'b0, bus.in_B} - {1'b0, bus.in_A};
    mag_d   = in_lt ? diff_ba[DATA_WIDTH-1:0] : diff_ab[DATA_WIDTH-1:0];
  end

  // Double-width shift so bits pushed past the MSB remain visible for error detection.
  always_comb begin
    shifted    = {{DATA_WIDTH{1'b0}}, mag_q} << bus.lop_nshift;
    shift_lost = |shifted[2*DATA_WIDTH-1:DATA_WIDTH];
    mag_nz     = |mag_q;
    need_fix   = (|norm_q) && !norm_q[DATA_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = StPred;
      StPred: state_d = StNorm;
      StNorm: state_d = StFix;
      StFix:  state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      mag_q   <= '0;
      norm_q  <= '0;
      shift_q <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      corr_q  <= 1'b0;
      hint_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_a_q <= bus.in_A;
            op_b_q <= bus.in_B;
            sign_q <= in_lt;
            mag_q  <= mag_d;
          end
        end
        StNorm: begin
          norm_q  <= shifted[DATA_WIDTH-1:0];
          shift_q <= mag_nz ? bus.lop_nshift : '0;
          hint_q  <= bus.lop_nshift_correct;
          zero_q  <= !mag_nz;
          corr_q  <= 1'b0;
          err_q   <= shift_lost || (bus.lop_not_zero != mag_nz);
        end
        StFix: begin
          if (need_fix) begin
            if (shift_q == SHIFT_WIDTH'(DATA_WIDTH - 1)) begin
              err_q <= 1'b1;
            end else begin
              norm_q  <= norm_q << 1;
              shift_q <= shift_q + SHIFT_WIDTH'(1);
              corr_q  <= 1'b1;
              // The predictor may only be one short; anything worse is reported.
              if (!norm_q[DATA_WIDTH-2]) err_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready   = (state_q == StIdle);
    bus.busy       = (state_q != StIdle);
    bus.lop_enable = (state_q == StPred);
    bus.out_valid  = (state_q == StDone);
    bus.lop_data_A = op_a_q;
    bus.lop_data_B = op_b_q;
    bus.res_mant   = norm_q;
    bus.res_shift  = shift_q;
    bus.res_sign   = sign_q;
    bus.res_zero   = zero_q;
    bus.res_corr   = corr_q;
    bus.res_hint   = hint_q;
    bus.res_err    = err_q;
  end

endmodule

// File: tb/tb_lop_norm_ctrl.sv
// Bench for lop_norm_ctrl: an LOP model with per-vector override, a vector table and a
// result scoreboard, plus backpressure and mid-operation reset sequences.
module tb_lop_norm_ctrl;
  localparam int W  = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lop_norm_ctrl_if #(.DATA_WIDTH(W), .SHIFT_WIDTH(SW)) bus ();

  lop_norm_ctrl #(.DATA_WIDTH(W), .SHIFT_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         force_en;
    logic [2:0] force_ns;
    logic [7:0] mant;
    logic [2:0] shift;
    logic       sign;
    logic       zero;
    logic       corr;
    logic       hint;
    logic       err;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb_q[$];
  bit          force_en = 1'b0;
  logic [2:0]  force_ns = 3'd0;

  function automatic logic [2:0] lzc(input logic [7:0] v);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(7 - i);
    return r;
  endfunction

  // Registered LOP predictor: exact leading-zero count unless the vector overrides it.
  always @(posedge clk) begin
    if (rst) begin
      bus.lop_nshift         <= '0;
      bus.lop_nshift_correct <= 1'b0;
      bus.lop_not_zero       <= 1'b0;
    end else if (bus.lop_enable) begin
      logic [7:0] d;
      d = (bus.lop_data_A > bus.lop_data_B) ? bus.lop_data_A - bus.lop_data_B
                                            : bus.lop_data_B - bus.lop_data_A;
      bus.lop_nshift         <= force_en ? force_ns : lzc(d);
      bus.lop_nshift_correct <= force_en;
      bus.lop_not_zero       <= (bus.lop_data_A != bus.lop_data_B);
    end
  end

  function automatic logic [15:0] res_now();
    return {bus.res_mant, bus.res_shift, bus.res_sign, bus.res_zero, bus.res_corr,
            bus.res_hint, bus.res_err};
  endfunction

  function automatic logic [15:0] exp_of(input vec_t v);
    return {v.mant, v.shift, v.sign, v.zero, v.corr, v.hint, v.err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at #1 after an edge with the DUT idle; returns at #1 after the accept edge.
  task automatic issue(input vec_t v);
    force_en     = v.force_en;
    force_ns     = v.force_ns;
    bus.in_A     = v.a;
    bus.in_B     = v.b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(exp_of(v));
    chk("pred_lop_enable", 32'(bus.lop_enable), 32'd1);
    chk("pred_lop_data_A", 32'(bus.lop_data_A), 32'(v.a));
    chk("pred_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop_compare(input string name);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(name, 32'(res_now()), 32'(e));
    end
  endtask

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int lat;
    logic [15:0] snap;
    int stray;

    //       a      b     fe  fns   mant   sh    sg    z     cr    hn    er
    vecs = '{
      '{8'h80, 8'h7F, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h55, 8'h55, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'h10, 8'h30, 1'b0, 3'd0, 8'h80, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h40, 8'h00, 1'b1, 3'd0, 8'h80, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{8'h01, 8'h00, 1'b1, 3'd3, 8'h10, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
      '{8'hFF, 8'h00, 1'b0, 3'd0, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h00, 8'hFF, 1'b0, 3'd0, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h40, 8'h00, 1'b1, 3'd2, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{8'h03, 8'h01, 1'b0, 3'd0, 8'h80, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h01, 8'h00, 1'b1, 3'd6, 8'h80, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{8'h55, 8'h55, 1'b1, 3'd5, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}
    };

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_A      = 8'hAA;
    bus.in_B      = 8'h01;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_lop_enable", 32'(bus.lop_enable), 32'd0);
    chk("rst_lop_data", 32'({bus.lop_data_A, bus.lop_data_B}), 32'd0);
    chk("rst_res", 32'(res_now()), 32'd0);
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i]);
      wait_result(lat);
      chk($sformatf("latency_%0d", i), 32'(lat), 32'd3);
      pop_compare($sformatf("result_%0d", i));
      @(posedge clk);
      #1;
      chk($sformatf("idle_after_%0d", i), 32'(bus.busy), 32'd0);
    end

    // Backpressure: result must hold while out_ready stays low.
    bus.out_ready = 1'b0;
    issue(vecs[0]);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'd3);
    snap = res_now();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_res_stable", 32'(res_now()), 32'(snap));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    pop_compare("bp_result");
    // A request presented during the handshake edge must not be taken.
    bus.in_A      = 8'h10;
    bus.in_B      = 8'h30;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("no_accept_on_handshake", 32'(bus.busy), 32'd0);
    chk("ready_after_handshake", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;

    // Reset while in NORM abandons the operation.
    issue(vecs[2]);
    @(posedge clk);
    #1;
    chk("norm_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_lop_enable", 32'(bus.lop_enable), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stray++;
    end
    chk("abort_no_result", 32'(stray), 32'd0);

    issue(vecs[3]);
    wait_result(lat);
    chk("recover_latency", 32'(lat), 32'd3);
    pop_compare("recover_result");
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
